// File: rtl/clock_enable_gen.sv
// ---------------------------------------------------------------------------
// clock_enable_gen
//
// Multi-channel clock-enable generator. Every channel divides the single
// system clock by a runtime-programmable divisor and emits a registered
// one-cycle strobe at the end of each period. In square mode it also emits
// a 50%-duty level with period 2N. A free-running counter is kept beside
// the channels so that the old divided-clock taps (free_count[k]) are still
// available. No new clocks are derived; everything runs on clk.
//
// Ports:
//   clk         system clock, the only clock of the block
//   reset       synchronous, active-high reset
//   en          global enable; low freezes every counter, ticks go low
//   div_in      divisor values, channel i at [i*DIV_W +: DIV_W]
//   div_load    per-channel load strobe for its div_in slice
//   mode        per channel: 0 = pulse, 1 = square
//   tick        registered one-cycle strobe at the end of each period
//   level       registered square output (square mode only, else 0)
//   pending     high while a loaded divisor waits for its period boundary
//   free_count  free-running enabled-cycle counter
// ---------------------------------------------------------------------------
module clock_enable_gen #(
   parameter int CHANNELS  = 4,
   parameter int DIV_W     = 16,
   parameter int CNT_W     = 32,
   parameter int RESET_DIV = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [CHANNELS*DIV_W-1:0] div_in,
   input  logic [CHANNELS-1:0]       div_load,
   input  logic [CHANNELS-1:0]       mode,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       level,
   output logic [CHANNELS-1:0]       pending,
   output logic [CNT_W-1:0]          free_count
);

   localparam logic [DIV_W-1:0] RESET_DIV_V = DIV_W'(RESET_DIV);
   localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   // Free-running counter. It only advances on enabled cycles and wraps
   // naturally at 2^CNT_W, so its bits behave like the legacy ripple of
   // divided clocks, each bit k toggling every 2^k enabled cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         free_count <= '0;
      end else if (en) begin
         free_count <= free_count + CNT_ONE;
      end
   end

   genvar i;
   generate
      for (i = 0; i < CHANNELS; i++) begin : g_ch
         logic [DIV_W-1:0] cnt;
         logic [DIV_W-1:0] div;
         logic [DIV_W-1:0] pend_div;
         logic [DIV_W-1:0] last_cnt;
         logic [DIV_W-1:0] load_val;
         logic             terminal;
         logic             tick_r;
         logic             level_r;
         logic             pending_r;

         // Terminal-cycle detection. A divisor of zero behaves as one, so
         // the last count value is 0 in both cases and the channel then
         // fires on every enabled cycle. The >= comparison keeps the
         // counter from running away should it ever sit above the last
         // value; in normal operation it is an equality test because cnt
         // is cleared whenever a new divisor takes effect.
         always_comb begin
            load_val = div_in[i*DIV_W +: DIV_W];
            last_cnt = (div == '0) ? '0 : (div - DIV_ONE);
            terminal = en && (cnt >= last_cnt);
         end

         // Period counter and strobe. With en low the count holds so that
         // a resumed channel finishes its period with no lost or extra
         // cycles, while the strobe is forced low.
         always_ff @(posedge clk) begin
            if (reset) begin
               cnt    <= '0;
               tick_r <= 1'b0;
            end else begin
               if (terminal) begin
                  cnt <= '0;
               end else if (en) begin
                  cnt <= cnt + DIV_ONE;
               end
               tick_r <= terminal;
            end
         end

         // Divisor update. A load is captured at any time, but the running
         // period always completes on the old divisor: the captured value
         // only moves into div at a terminal cycle. A load that lands on a
         // terminal cycle goes straight into div for the next period. A
         // later load while one is still waiting simply overwrites it.
         always_ff @(posedge clk) begin
            if (reset) begin
               div       <= RESET_DIV_V;
               pend_div  <= '0;
               pending_r <= 1'b0;
            end else if (div_load[i]) begin
               if (terminal) begin
                  div       <= load_val;
                  pending_r <= 1'b0;
               end else begin
                  pend_div  <= load_val;
                  pending_r <= 1'b1;
               end
            end else if (terminal && pending_r) begin
               div       <= pend_div;
               pending_r <= 1'b0;
            end
         end

         // Square output. Mode is looked at every cycle: pulse mode parks
         // the level at 0, so switching to square always starts from 0 and
         // the first rising edge comes with the next terminal cycle.
         always_ff @(posedge clk) begin
            if (reset) begin
               level_r <= 1'b0;
            end else if (!mode[i]) begin
               level_r <= 1'b0;
            end else if (terminal) begin
               level_r <= ~level_r;
            end
         end

         assign tick[i]    = tick_r;
         assign level[i]   = level_r;
         assign pending[i] = pending_r;
      end
   endgenerate

endmodule

// File: tb/tb_clock_enable_gen.sv
// ---------------------------------------------------------------------------
// tb_clock_enable_gen
//
// Scoreboard bench for clock_enable_gen with the default parameters. The
// stimulus process drives one cycle of inputs shortly after a falling edge
// and pushes the hand-derived outputs expected after the following rising
// edge; the monitor samples on every falling edge and compares against the
// oldest queued expectation.
// ---------------------------------------------------------------------------
module tb_clock_enable_gen;

   localparam int CH = 4;
   localparam int DW = 16;
   localparam int CW = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [CH*DW-1:0] div_in;
   logic [CH-1:0]    div_load;
   logic [CH-1:0]    mode;
   logic [CH-1:0]    tick;
   logic [CH-1:0]    level;
   logic [CH-1:0]    pending;
   logic [CW-1:0]    free_count;

   typedef struct {
      string       name;
      logic [3:0]  tick_mask;
      logic [3:0]  tick_exp;
      logic [3:0]  level_mask;
      logic [3:0]  level_exp;
      logic [3:0]  pend_mask;
      logic [3:0]  pend_exp;
      logic        fc_chk;
      logic [31:0] fc_exp;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   clock_enable_gen #(
      .CHANNELS  (CH),
      .DIV_W     (DW),
      .CNT_W     (CW),
      .RESET_DIV (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .div_in     (div_in),
      .div_load   (div_load),
      .mode       (mode),
      .tick       (tick),
      .level      (level),
      .pending    (pending),
      .free_count (free_count)
   );

   // 100 MHz-style free-running clock for the bench
   always #5 clk = ~clk;

   // Compare the sampled outputs against one queued expectation
   task automatic checkOutput(input exp_t e);
      if (e.tick_mask != 4'h0) begin
         checks++;
         if ((tick & e.tick_mask) !== (e.tick_exp & e.tick_mask)) begin
            errors++;
            $display("[TB] FAIL %s tick got %b want %b mask %b", e.name, tick, e.tick_exp, e.tick_mask);
         end
      end
      if (e.level_mask != 4'h0) begin
         checks++;
         if ((level & e.level_mask) !== (e.level_exp & e.level_mask)) begin
            errors++;
            $display("[TB] FAIL %s level got %b want %b mask %b", e.name, level, e.level_exp, e.level_mask);
         end
      end
      if (e.pend_mask != 4'h0) begin
         checks++;
         if ((pending & e.pend_mask) !== (e.pend_exp & e.pend_mask)) begin
            errors++;
            $display("[TB] FAIL %s pending got %b want %b mask %b", e.name, pending, e.pend_exp, e.pend_mask);
         end
      end
      if (e.fc_chk) begin
         checks++;
         if (free_count !== e.fc_exp) begin
            errors++;
            $display("[TB] FAIL %s free_count got %0d want %0d", e.name, free_count, e.fc_exp);
         end
      end
   endtask

   // Drive one cycle of inputs and queue what must appear after the edge
   task automatic applyStimulus(input string name, input logic rst_v, input logic en_v,
                                input logic [3:0] load_v,
                                input logic [3:0] t_mask, input logic [3:0] t_exp,
                                input logic [3:0] l_mask, input logic [3:0] l_exp,
                                input logic [3:0] p_mask, input logic [3:0] p_exp,
                                input logic fc_chk, input logic [31:0] fc_exp);
      exp_t e;
      @(negedge clk);
      #1;
      reset    = rst_v;
      en       = en_v;
      div_load = load_v;
      e.name       = name;
      e.tick_mask  = t_mask;
      e.tick_exp   = t_exp;
      e.level_mask = l_mask;
      e.level_exp  = l_exp;
      e.pend_mask  = p_mask;
      e.pend_exp   = p_exp;
      e.fc_chk     = fc_chk;
      e.fc_exp     = fc_exp;
      if ((t_mask | l_mask | p_mask) != 4'h0 || fc_chk) begin
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_div(input int ch, input logic [15:0] v);
      div_in[ch*DW +: DW] = v;
   endtask

   // Monitor: one sample per falling edge, popped in issue order
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
         end
      end
   end

   // Directed stimulus
   initial begin
      logic [3:0] t;
      logic [3:0] l;
      logic [3:0] p;
      logic [3:0] ld;
      logic       rs;
      logic       ev;
      logic [31:0] fc;

      reset    = 1'b1;
      en       = 1'b0;
      div_in   = '0;
      div_load = '0;
      mode     = '0;

      // Reset state and default divisor of 2 on every channel
      applyStimulus("reset0", 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 32'd0);
      applyStimulus("reset1", 1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         t = (k % 2 == 0) ? 4'hF : 4'h0;
         applyStimulus("default_run", 1'b0, 1'b1, 4'h0, 4'hF, t, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 32'(k));
      end

      // ch1 div 5 pulse, ch2 div 3 square, both loaded at reset release
      mode = 4'b0100;
      set_div(1, 16'd5);
      set_div(2, 16'd3);
      applyStimulus("reset_b", 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 32'd0);
      for (int k = 1; k <= 17; k++) begin
         t[0] = (k % 2 == 0);
         t[3] = (k % 2 == 0);
         t[1] = (k == 2) || (k == 7) || (k == 12) || (k == 17);
         t[2] = (k == 2) || (k == 5) || (k == 8) || (k == 11) || (k == 14) || (k == 17);
         l    = 4'h0;
         l[2] = (k >= 2 && k <= 4) || (k >= 8 && k <= 10) || (k >= 14 && k <= 16);
         p    = (k == 1) ? 4'b0110 : 4'b0000;
         ld   = (k == 1) ? 4'b0110 : 4'b0000;
         applyStimulus("div5_sq3", 1'b0, 1'b1, ld, 4'hF, t, 4'hF, l, 4'hF, p, 1'b1, 32'(k));
      end

      // ch0 div 4, reload to 7 mid-period, then 11 overwritten by 9
      mode = 4'b0000;
      applyStimulus("reset_c", 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 32'd0);
      for (int k = 1; k <= 34; k++) begin
         case (k)
            1:       set_div(0, 16'd4);
            8:       set_div(0, 16'd7);
            19:      set_div(0, 16'd11);
            default: set_div(0, 16'd9);
         endcase
         ld   = (k == 1 || k == 8 || k == 19 || k == 21) ? 4'b0001 : 4'b0000;
         t    = 4'h0;
         t[0] = (k == 2) || (k == 6) || (k == 10) || (k == 17) || (k == 24) || (k == 33);
         p    = 4'h0;
         p[0] = (k == 1) || (k >= 8 && k <= 9) || (k >= 19 && k <= 23);
         applyStimulus("reload", 1'b0, 1'b1, ld, 4'b0001, t, 4'h0, 4'h0, 4'b0001, p, 1'b1, 32'(k));
      end

      // en low for 10 cycles with ch0 at cnt 2 of div 4; load 3 while frozen
      applyStimulus("reset_d", 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 32'd0);
      for (int k = 1; k <= 27; k++) begin
         set_div(0, (k == 1) ? 16'd4 : 16'd3);
         ev   = !(k >= 13 && k <= 22);
         ld   = (k == 1 || k == 13) ? 4'b0001 : 4'b0000;
         t    = 4'h0;
         t[0] = (k == 2) || (k == 6) || (k == 10) || (k == 24) || (k == 27);
         p    = 4'h0;
         p[0] = (k == 1) || (k >= 13 && k <= 23);
         fc   = (k <= 12) ? 32'(k) : ((k <= 22) ? 32'd12 : 32'(k - 10));
         applyStimulus("en_hold", 1'b0, ev, ld, ev ? 4'b0001 : 4'hF, t, 4'h0, 4'h0, 4'b0001, p, 1'b1, fc);
      end

      // div 0 on ch3, then reset mid-period with ch0 load pending
      mode = 4'b0100;
      set_div(3, 16'd0);
      set_div(0, 16'd6);
      applyStimulus("reset_e", 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 32'd0);
      for (int k = 1; k <= 12; k++) begin
         rs = (k == 8);
         ld = (k == 1) ? 4'b1000 : ((k == 7 || k == 8) ? 4'b0001 : 4'b0000);
         l  = 4'h0;
         if (k <= 7) begin
            t    = 4'h0;
            t[0] = (k % 2 == 0);
            t[3] = (k >= 2);
            l[2] = (k == 2) || (k == 3) || (k == 6) || (k == 7);
            p    = (k == 1) ? 4'b1000 : ((k == 7) ? 4'b0001 : 4'b0000);
            applyStimulus("div0", rs, 1'b1, ld, 4'b1001, t, 4'hF, l, 4'hF, p, 1'b1, 32'(k));
         end else begin
            t    = (k != 8 && k % 2 == 0) ? 4'hF : 4'h0;
            l[2] = (k == 10) || (k == 11);
            applyStimulus("mid_reset", rs, 1'b1, ld, 4'hF, t, 4'hF, l, 4'hF, 4'h0, 1'b1, 32'(k - 8));
         end
      end

      div_load = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain queue has %0d entries want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
